ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
Instruction fetch unit that owns the architectural PC register. It consumes the next-PC value produced by the combinational next-PC stage, and feeds the current PC back to that stage. It issues one instruction-memory read per instruction over a valid/ready request plus response-valid interface. It presents the fetched instruction to decode through a valid/ready handshake. It then holds until the back end signals commit, and only then loads the next PC.

Parameters:
RESET_PC, 64'h80000000, PC value loaded on reset.
CNT_W, 32, width of the committed-instruction counter.

Ports:
clk  input  1  system clock; all state on rising edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
dnpc  input  64  next PC from the next-PC stage.
commit  input  1  one-cycle pulse: the current instruction has completed and dnpc is final.
halt  input  1  stop fetching (ebreak / simulation end).
pc  output  64  current architectural PC, fed to the next-PC stage.
ireq_valid  output  1  instruction-memory read request valid.
ireq_ready  input  1  memory accepts the request.
ireq_addr  output  64  request address; always equals pc.
iresp_valid  input  1  read data valid (one-cycle pulse).
iresp_data  input  32  instruction word.
iresp_err  input  1  access fault, qualified by iresp_valid.
inst_valid  output  1  instruction available to decode.
inst_ready  input  1  decode accepts the instruction.
inst  output  32  fetched instruction.
inst_pc  output  64  PC of inst.
fault  output  1  sticky fetch fault (misaligned or access error).
halted  output  1  sticky; block is in S_HALT.
inst_cnt  output  CNT_W  number of committed instructions.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC; state=S_IDLE.
  - ireq_valid=0, inst_valid=0, inst=0, inst_pc=0.
  - fault=0, halted=0, inst_cnt=0.
- FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT, S_EXEC, S_HALT.
  - S_IDLE: unconditionally moves to S_REQ on the next clock. The first request is asserted 1 cycle after reset release.
  - S_REQ: ireq_valid=1, ireq_addr=pc.
    - ireq_valid stays high, with a stable address, until ireq_ready.
    - On ireq_valid&&ireq_ready, go to S_WAIT.
  - S_WAIT: ireq_valid=0; wait for iresp_valid.
    - iresp_valid && !iresp_err: inst<=iresp_data, inst_pc<=pc, go to S_OUT.
    - iresp_valid && iresp_err: fault<=1, go to S_HALT.
    - A response may arrive in the cycle right after acceptance (minimum request-to-decode latency is 2 cycles).
  - S_OUT: inst_valid=1; inst and inst_pc are held stable while inst_valid=1 && !inst_ready. On inst_ready, inst_valid drops next cycle and the FSM goes to S_EXEC.
  - S_EXEC: wait for commit.
    - On commit: inst_cnt<=inst_cnt+1 (wraps modulo 2^CNT_W).
    - If dnpc[1:0]!=0: fault<=1, pc unchanged, go to S_HALT.
    - Otherwise pc<=dnpc and go to S_REQ.
- commit is ignored in every state other than S_EXEC; the counter and pc are unaffected.
- halt priority:
  - Sampled high in S_REQ, S_OUT or S_EXEC: go to S_HALT next cycle.
  - Sampled high in S_EXEC with commit: the commit is still applied (pc and inst_cnt update) before halting.
  - Sampled high in S_WAIT: the outstanding response is awaited and discarded, then the FSM goes to S_HALT. An outstanding bus transaction is never abandoned.
- S_HALT: absorbing; halted=1, ireq_valid=0, inst_valid=0. Only reset leaves it.
- Reset mid-transaction: all state clears immediately. Any iresp_valid arriving after reset release while in S_IDLE/S_REQ is ignored.
- pc updates only on commit in S_EXEC, so the next-PC stage sees a stable pc for the whole instruction.

Test Plan:
- Reset release, memory always ready, 1-cycle response 32'h00000413 -> ireq_valid at cycle 1 with addr 64'h80000000; inst_valid at cycle 3 with inst=32'h00000413 and inst_pc=64'h80000000.
- Commit with dnpc=64'h80000004, then commit with dnpc=64'h80000100 (jump) -> next requests at 64'h80000004 then 64'h80000100; inst_cnt=2.
- ireq_ready held low 3 cycles, then inst_ready held low 4 cycles -> ireq_addr stable through the stall; inst and inst_pc stable; exactly one request and one decode handshake.
- Commit with dnpc=64'h80000006 -> fault=1, halted=1, pc stays 64'h80000004, no further ireq_valid.
- iresp_err=1 on the response -> fault=1, halted=1, inst_valid never asserted.
- halt asserted in S_WAIT, then response arrives -> response discarded, halted=1. Then drive rst low mid-stall -> pc=64'h80000000 and all outputs at reset values immediately.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, fetches one instruction per commit, hands it to decode.
// Latency: request 1 cycle after reset release, decode valid 2+ cycles after request.
// Backpressure: holds ireq_valid/addr until ireq_ready, holds inst/inst_pc until inst_ready.
module ifu_fetch #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      dnpc,
    input  logic             commit,
    input  logic             halt,
    output logic [63:0]      pc,
    output logic             ireq_valid,
    input  logic             ireq_ready,
    output logic [63:0]      ireq_addr,
    input  logic             iresp_valid,
    input  logic [31:0]      iresp_data,
    input  logic             iresp_err,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [63:0]      inst_pc,
    output logic             fault,
    output logic             halted,
    output logic [CNT_W-1:0] inst_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t state;
    logic   halt_pend;

    assign ireq_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            ireq_valid <= 1'b0;
            inst_valid <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            fault      <= 1'b0;
            halted     <= 1'b0;
            inst_cnt   <= '0;
            halt_pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ireq_valid <= 1'b1;
                    state      <= S_REQ;
                end
                S_REQ: begin
                    // An accepted request must see its response, so a halt in the
                    // acceptance cycle is deferred to the end of S_WAIT.
                    if (ireq_ready) begin
                        ireq_valid <= 1'b0;
                        halt_pend  <= halt;
                        state      <= S_WAIT;
                    end else if (halt) begin
                        ireq_valid <= 1'b0;
                        halted     <= 1'b1;
                        state      <= S_HALT;
                    end
                end
                S_WAIT: begin
                    if (halt) begin
                        halt_pend <= 1'b1;
                    end
                    if (iresp_valid) begin
                        if (iresp_err) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else if (halt_pend || halt) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            inst       <= iresp_data;
                            inst_pc    <= pc;
                            inst_valid <= 1'b1;
                            state      <= S_OUT;
                        end
                    end
                end
                S_OUT: begin
                    if (halt) begin
                        inst_valid <= 1'b0;
                        halted     <= 1'b1;
                        state      <= S_HALT;
                    end else if (inst_ready) begin
                        inst_valid <= 1'b0;
                        state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (commit) begin
                        inst_cnt <= inst_cnt + CNT_W'(1);
                        if (dnpc[1:0] != 2'b00) begin
                            fault  <= 1'b1;
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            pc <= dnpc;
                            if (halt) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                ireq_valid <= 1'b1;
                                state      <= S_REQ;
                            end
                        end
                    end else if (halt) begin
                        halted <= 1'b1;
                        state  <= S_HALT;
                    end
                end
                S_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    ireq_valid <= 1'b0;
                    inst_valid <= 1'b0;
                    halted     <= 1'b1;
                    state      <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed vector table plus hand-written stall / halt / reset sequences for ifu_fetch.
module tb_ifu_fetch;

    localparam logic [63:0] P0 = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] dnpc;
    logic        commit, halt;
    logic [63:0] pc;
    logic        ireq_valid, ireq_ready;
    logic [63:0] ireq_addr;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        iresp_err;
    logic        inst_valid, inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        fault, halted;
    logic [31:0] inst_cnt;

    ifu_fetch #(.RESET_PC(P0), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .dnpc(dnpc), .commit(commit), .halt(halt), .pc(pc),
        .ireq_valid(ireq_valid), .ireq_ready(ireq_ready), .ireq_addr(ireq_addr),
        .iresp_valid(iresp_valid), .iresp_data(iresp_data), .iresp_err(iresp_err),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
        .fault(fault), .halted(halted), .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int nreq = 0;
    int ndec = 0;

    always @(posedge clk) begin
        if (ireq_valid && ireq_ready) nreq++;
        if (inst_valid && inst_ready) ndec++;
    end

    typedef struct {
        logic        rst_v;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        err;
        logic        irdy;
        logic        cm;
        logic [63:0] dn;
        logic        hl;
        logic [63:0] epc;
        logic [3:0]  efl;   // {ireq_valid, inst_valid, fault, halted}
        logic [31:0] einst;
        logic [63:0] eipc;
        logic [31:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic err, input logic irdy,
                                input logic cm, input logic [63:0] dn, input logic hl,
                                input logic [63:0] epc, input logic [3:0] efl,
                                input logic [31:0] einst, input logic [63:0] eipc,
                                input logic [31:0] ecnt);
        vec_t v;
        v.rst_v = r; v.rdy = rdy; v.rv = rv; v.rd = rd; v.err = err; v.irdy = irdy;
        v.cm = cm; v.dn = dn; v.hl = hl; v.epc = epc; v.efl = efl;
        v.einst = einst; v.eipc = eipc; v.ecnt = ecnt;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dnpc = '0; commit = 0; halt = 0; ireq_ready = 0;
        iresp_valid = 0; iresp_data = '0; iresp_err = 0; inst_ready = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " pc"}, pc, P0);
        chk({tag, " addr"}, ireq_addr, P0);
        chk({tag, " flags"}, {60'd0, ireq_valid, inst_valid, fault, halted}, 64'd0);
        chk({tag, " inst"}, {32'd0, inst}, 64'd0);
        chk({tag, " inst_pc"}, inst_pc, 64'd0);
        chk({tag, " cnt"}, {32'd0, inst_cnt}, 64'd0);
    endtask

    initial begin
        int base_req, base_dec;
        rst = 0;
        idle_inputs();

        //   rst rdy rv data           err irdy cm dnpc              hl  pc          flags    inst           inst_pc    cnt
        add(0, 0, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b0000, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b1000, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b0000, 32'h0,         64'h0,     0);
        add(1, 1, 1, 32'h00000413,   0, 0, 0, 64'h0,            0, P0,          4'b0100, 32'h00000413,  P0,        0);
        add(1, 1, 0, 32'h0,          0, 1, 0, 64'h0,            0, P0,          4'b0000, 32'h00000413,  P0,        0);
        add(1, 1, 0, 32'h0,          0, 0, 1, P0 + 64'h4,       0, P0 + 64'h4,  4'b1000, 32'h00000413,  P0,        1);
        add(1, 1, 0, 32'h0,          0, 0, 1, 64'h1234_5678,    0, P0 + 64'h4,  4'b0000, 32'h00000413,  P0,        1);
        add(1, 1, 1, 32'h00100093,   0, 0, 1, 64'h1234_5678,    0, P0 + 64'h4,  4'b0100, 32'h00100093,  P0 + 64'h4, 1);
        add(1, 1, 0, 32'h0,          0, 1, 0, 64'h0,            0, P0 + 64'h4,  4'b0000, 32'h00100093,  P0 + 64'h4, 1);
        add(1, 1, 0, 32'h0,          0, 0, 1, P0 + 64'h100,     0, P0 + 64'h100, 4'b1000, 32'h00100093, P0 + 64'h4, 2);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0 + 64'h100, 4'b0000, 32'h00100093, P0 + 64'h4, 2);
        add(1, 1, 1, 32'h00000073,   0, 0, 0, 64'h0,            0, P0 + 64'h100, 4'b0100, 32'h00000073, P0 + 64'h100, 2);
        add(1, 1, 0, 32'h0,          0, 1, 0, 64'h0,            0, P0 + 64'h100, 4'b0000, 32'h00000073, P0 + 64'h100, 2);
        add(1, 1, 0, 32'h0,          0, 0, 1, P0 + 64'h200,     1, P0 + 64'h200, 4'b0001, 32'h00000073, P0 + 64'h100, 3);
        add(1, 1, 1, 32'hffff,       0, 1, 1, P0 + 64'h300,     0, P0 + 64'h200, 4'b0001, 32'h00000073, P0 + 64'h100, 3);
        add(0, 0, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b0000, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b1000, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b0000, 32'h0,         64'h0,     0);
        add(1, 1, 1, 32'hffff_ffff,  1, 0, 0, 64'h0,            0, P0,          4'b0011, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 1, 0, 64'h0,            0, P0,          4'b0011, 32'h0,         64'h0,     0);
        add(0, 0, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b0000, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b1000, 32'h0,         64'h0,     0);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0,          4'b0000, 32'h0,         64'h0,     0);
        add(1, 1, 1, 32'h00000413,   0, 0, 0, 64'h0,            0, P0,          4'b0100, 32'h00000413,  P0,        0);
        add(1, 1, 0, 32'h0,          0, 1, 0, 64'h0,            0, P0,          4'b0000, 32'h00000413,  P0,        0);
        add(1, 1, 0, 32'h0,          0, 0, 1, P0 + 64'h4,       0, P0 + 64'h4,  4'b1000, 32'h00000413,  P0,        1);
        add(1, 1, 0, 32'h0,          0, 0, 0, 64'h0,            0, P0 + 64'h4,  4'b0000, 32'h00000413,  P0,        1);
        add(1, 1, 1, 32'h00000013,   0, 0, 0, 64'h0,            0, P0 + 64'h4,  4'b0100, 32'h00000013,  P0 + 64'h4, 1);
        add(1, 1, 0, 32'h0,          0, 1, 0, 64'h0,            0, P0 + 64'h4,  4'b0000, 32'h00000013,  P0 + 64'h4, 1);
        add(1, 1, 0, 32'h0,          0, 0, 1, P0 + 64'h6,       0, P0 + 64'h4,  4'b0011, 32'h00000013,  P0 + 64'h4, 2);
        add(1, 1, 0, 32'h0,          0, 0, 1, P0 + 64'h8,       0, P0 + 64'h4,  4'b0011, 32'h00000013,  P0 + 64'h4, 2);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst_v; ireq_ready = tbl[i].rdy; iresp_valid = tbl[i].rv;
            iresp_data = tbl[i].rd; iresp_err = tbl[i].err; inst_ready = tbl[i].irdy;
            commit = tbl[i].cm; dnpc = tbl[i].dn; halt = tbl[i].hl;
            tick();
            chk($sformatf("row%0d pc", i), pc, tbl[i].epc);
            chk($sformatf("row%0d addr", i), ireq_addr, tbl[i].epc);
            chk($sformatf("row%0d flags", i), {60'd0, ireq_valid, inst_valid, fault, halted},
                {60'd0, tbl[i].efl});
            chk($sformatf("row%0d inst", i), {32'd0, inst}, {32'd0, tbl[i].einst});
            chk($sformatf("row%0d inst_pc", i), inst_pc, tbl[i].eipc);
            chk($sformatf("row%0d cnt", i), {32'd0, inst_cnt}, {32'd0, tbl[i].ecnt});
        end

        // Request and decode stalls; a stray response during S_IDLE must be ignored.
        idle_inputs();
        rst = 0;
        tick();
        rst = 1; iresp_valid = 1; iresp_data = 32'hdead_beef;
        tick();
        iresp_valid = 0;
        chk("stall first req", {63'd0, ireq_valid}, 64'd1);
        base_req = nreq;
        base_dec = ndec;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall req_vld c%0d", c), {63'd0, ireq_valid}, 64'd1);
            chk($sformatf("stall addr c%0d", c), ireq_addr, P0);
            chk($sformatf("stall no inst c%0d", c), {63'd0, inst_valid}, 64'd0);
        end
        ireq_ready = 1;
        tick();
        ireq_ready = 0;
        chk("stall req dropped", {63'd0, ireq_valid}, 64'd0);
        iresp_valid = 1; iresp_data = 32'h00a00513;
        tick();
        iresp_valid = 0;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("dec stall vld c%0d", c), {63'd0, inst_valid}, 64'd1);
            chk($sformatf("dec stall inst c%0d", c), {32'd0, inst}, 64'h00a00513);
            chk($sformatf("dec stall inst_pc c%0d", c), inst_pc, P0);
            tick();
        end
        inst_ready = 1;
        tick();
        inst_ready = 0;
        chk("dec vld dropped", {63'd0, inst_valid}, 64'd0);
        chk("one request", 64'(nreq - base_req), 64'd1);
        chk("one decode", 64'(ndec - base_dec), 64'd1);
        commit = 1; dnpc = P0 + 64'h4;
        tick();
        commit = 0;
        chk("stall next pc", pc, P0 + 64'h4);
        chk("stall next req", {63'd0, ireq_valid}, 64'd1);
        tick();
        #2;
        rst = 0;
        #1;
        chk_reset_vals("async rst");

        // Halt while a response is outstanding.
        tick();
        rst = 1;
        tick();
        ireq_ready = 1;
        tick();
        ireq_ready = 0;
        halt = 1;
        tick();
        halt = 0;
        chk("halt wait not halted", {63'd0, halted}, 64'd0);
        chk("halt wait no req", {63'd0, ireq_valid}, 64'd0);
        tick();
        chk("halt wait still waiting", {63'd0, halted}, 64'd0);
        iresp_valid = 1; iresp_data = 32'h1234_5678;
        tick();
        iresp_valid = 0;
        chk("halt after rsp", {63'd0, halted}, 64'd1);
        chk("halt rsp discarded", {32'd0, inst}, 64'd0);
        chk("halt no inst_vld", {63'd0, inst_valid}, 64'd0);
        chk("halt no fault", {63'd0, fault}, 64'd0);
        ireq_ready = 1; inst_ready = 1;
        tick();
        chk("halt absorbing", {62'd0, ireq_valid, halted}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
